// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: state encoding,
// per-cycle control bundle and helpers that build the common control patterns.
package pipe_ctrl_pkg;

   localparam int CNT_W_DEF = 32;
   localparam int DCNT_W    = 3;

   typedef enum logic [2:0] {
      S_RST   = 3'd0,
      S_RUN   = 3'd1,
      S_FLUSH = 3'd2,
      S_DRAIN = 3'd3,
      S_HALT  = 3'd4,
      S_STEP  = 3'd5
   } state_e;

   typedef struct packed {
      logic if_stall;
      logic id_stall;
      logic id_clr;
      logic ex_clr;
      logic redirect;
   } ctl_t;

   // Redirect bubbles ID and EX; the fetch hold only matters while draining.
   function automatic ctl_t redirect_ctl(logic hold_if);
      ctl_t c;
      c          = '0;
      c.if_stall = hold_if;
      c.id_clr   = 1'b1;
      c.ex_clr   = 1'b1;
      c.redirect = 1'b1;
      return c;
   endfunction

   function automatic ctl_t load_use_ctl();
      ctl_t c;
      c          = '0;
      c.if_stall = 1'b1;
      c.id_stall = 1'b1;
      c.ex_clr   = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/debug request inputs and stall/flush/status outputs of the sequencer.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
   logic             i_mem_hazard;
   logic             i_branch_taken;
   logic             i_halt_req;
   logic             i_step;
   logic             i_cnt_clr;
   logic             o_if_stall;
   logic             o_id_stall;
   logic             o_id_clr;
   logic             o_ex_clr;
   logic             o_redirect;
   logic             o_halted;
   logic             o_step_done;
   logic [CNT_W-1:0] o_stall_cnt;
   logic [CNT_W-1:0] o_flush_cnt;

   modport master (
      output i_mem_hazard, i_branch_taken, i_halt_req, i_step, i_cnt_clr,
      input  o_if_stall, o_id_stall, o_id_clr, o_ex_clr, o_redirect,
             o_halted, o_step_done, o_stall_cnt, o_flush_cnt
   );

   modport slave (
      input  i_mem_hazard, i_branch_taken, i_halt_req, i_step, i_cnt_clr,
      output o_if_stall, o_id_stall, o_id_clr, o_ex_clr, o_redirect,
             o_halted, o_step_done, o_stall_cnt, o_flush_cnt
   );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Wrapping event counter; synchronous clear takes priority over increment.
module pipe_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)      cnt_d = '0;
      else if (inc) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch
// flushes, debug halt/drain/single-step. Controls respond in the same cycle.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
);

   localparam logic [DCNT_W-1:0] FL_RELOAD = DCNT_W'(FLUSH_CYCLES - 1);
   localparam logic [DCNT_W-1:0] DR_RELOAD = DCNT_W'(DRAIN_CYCLES);

   state_e            state_q, state_d;
   logic [DCNT_W-1:0] cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic              step_q, step_d;
   logic              done_q, done_d;

   ctl_t ctl;
   logic halted;
   logic stall_inc, flush_inc;
   logic pend_live;

   always_comb begin
      // A dropped request cancels any halt that was waiting for the flush to end.
      pend_live = pend_q & bus.i_halt_req;
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_live;
      step_d    = step_q;
      done_d    = 1'b0;
      ctl       = '0;
      halted    = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;

      unique case (state_q)
         S_RST: begin
            ctl.if_stall = 1'b1;
            ctl.id_clr   = 1'b1;
            ctl.ex_clr   = 1'b1;
            state_d      = S_RUN;
         end

         S_RUN: begin
            if (bus.i_branch_taken) begin
               ctl       = redirect_ctl(1'b0);
               flush_inc = 1'b1;
               pend_d    = pend_live | bus.i_halt_req;
               if (FLUSH_CYCLES > 1) begin
                  state_d = S_FLUSH;
                  cnt_d   = FL_RELOAD;
               end
            end else if (bus.i_mem_hazard) begin
               ctl       = load_use_ctl();
               stall_inc = 1'b1;
               pend_d    = pend_live | bus.i_halt_req;
            end else if (bus.i_halt_req | pend_live) begin
               state_d = S_DRAIN;
               cnt_d   = DR_RELOAD;
               pend_d  = 1'b0;
               step_d  = 1'b0;
            end
         end

         S_FLUSH: begin
            ctl.id_clr = 1'b1;
            pend_d     = pend_live | bus.i_halt_req;
            if (bus.i_branch_taken) begin
               ctl       = redirect_ctl(1'b0);
               flush_inc = 1'b1;
               cnt_d     = FL_RELOAD;
            end else if (cnt_q == DCNT_W'(1)) begin
               state_d = S_RUN;
            end else begin
               cnt_d = cnt_q - DCNT_W'(1);
            end
         end

         S_DRAIN: begin
            if (bus.i_branch_taken) begin
               ctl       = redirect_ctl(1'b1);
               flush_inc = 1'b1;
               cnt_d     = DR_RELOAD;
            end else if (bus.i_mem_hazard) begin
               ctl       = load_use_ctl();
               stall_inc = 1'b1;
            end else begin
               ctl.if_stall = 1'b1;
               ctl.id_clr   = 1'b1;
               if (cnt_q == DCNT_W'(1)) begin
                  state_d = S_HALT;
                  done_d  = step_q;
                  step_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q - DCNT_W'(1);
               end
            end
         end

         S_HALT: begin
            ctl.if_stall = 1'b1;
            ctl.id_stall = 1'b1;
            halted       = 1'b1;
            if (!bus.i_halt_req)  state_d = S_RUN;
            else if (bus.i_step)  state_d = S_STEP;
         end

         S_STEP: begin
            if (bus.i_branch_taken) begin
               ctl       = redirect_ctl(1'b0);
               flush_inc = 1'b1;
            end else if (bus.i_mem_hazard) begin
               ctl       = load_use_ctl();
               stall_inc = 1'b1;
            end
            state_d = S_DRAIN;
            cnt_d   = DR_RELOAD;
            pend_d  = 1'b0;
            step_d  = 1'b1;
         end

         default: state_d = S_RST;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RST;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         step_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         step_q  <= step_d;
         done_q  <= done_d;
      end
   end

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc),
      .clr (bus.i_cnt_clr),
      .cnt (bus.o_stall_cnt)
   );

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .inc (flush_inc),
      .clr (bus.i_cnt_clr),
      .cnt (bus.o_flush_cnt)
   );

   assign bus.o_if_stall  = ctl.if_stall;
   assign bus.o_id_stall  = ctl.id_stall;
   assign bus.o_id_clr    = ctl.id_clr;
   assign bus.o_ex_clr    = ctl.ex_clr;
   assign bus.o_redirect  = ctl.redirect;
   assign bus.o_halted    = halted;
   assign bus.o_step_done = done_q;

endmodule
